// File: rtl/imem_program_loader.sv
// Byte-serial boot loader: unpacks a framed, XOR-checksummed program into instruction memory
// and keeps the processor held until the whole frame has been verified.
module imem_program_loader #(
    parameter int ADDR_W    = 8,
    parameter int INST_W    = 25,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [8:0]        word_count
);

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        B0,
        B1,
        B2,
        B3,
        WR,
        CHK,
        DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]        n_words;
    logic [7:0]        chk;
    logic [INST_W-1:0] word;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        wc;
    logic              hold;
    logic              err_q;
    logic              xfer;
    logic              abort;
    logic              last_word;

    // Ready depends on state only, so byte_valid never feeds back into byte_ready.
    assign byte_ready = (state == HDR) || (state == B0) || (state == B1) ||
                        (state == B2)  || (state == B3) || (state == CHK);
    assign xfer       = byte_valid & byte_ready;
    assign imem_we    = (state == WR);
    assign busy       = byte_ready || (state == WR);
    assign done       = (state == DONE);
    assign imem_addr  = addr;
    assign imem_wdata = word;
    assign cpu_hold   = hold;
    assign err        = err_q;
    assign word_count = wc;
    assign last_word  = ((wc + 9'd1) == {1'b0, n_words});

    assign abort = xfer && (((state == B0) && (byte_data[7:1] != 7'd0)) ||
                            ((state == CHK) && (byte_data != chk)));

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = HDR;
            HDR:  if (xfer) state_next = (byte_data == 8'd0) ? CHK : B0;
            B0:   if (xfer) state_next = abort ? IDLE : B1;
            B1:   if (xfer) state_next = B2;
            B2:   if (xfer) state_next = B3;
            B3:   if (xfer) state_next = WR;
            WR:   state_next = last_word ? CHK : B0;
            CHK:  if (xfer) state_next = abort ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte 0 of each word carries only the top instruction bit; the rest shift in MSB first.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            n_words <= 8'd0;
            chk     <= 8'd0;
            word    <= '0;
            addr    <= ADDR_W'(BASE_ADDR);
            wc      <= 9'd0;
            hold    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                chk   <= 8'd0;
                wc    <= 9'd0;
                addr  <= ADDR_W'(BASE_ADDR);
                hold  <= 1'b1;
                err_q <= 1'b0;
            end
            if (xfer) begin
                chk <= chk ^ byte_data;
            end
            if ((state == HDR) && xfer) begin
                n_words <= byte_data;
            end
            if ((state == B0) && xfer) begin
                word <= INST_W'(byte_data[0]);
            end
            if (((state == B1) || (state == B2) || (state == B3)) && xfer) begin
                word <= {word[INST_W-9:0], byte_data};
            end
            if (state == WR) begin
                addr <= addr + ADDR_W'(1);
                wc   <= wc + 9'd1;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
            if ((state == CHK) && xfer && (byte_data == chk)) begin
                hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a frame-level reference model checked every cycle,
// plus literal expectations for each directed case.
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [24:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  word_count;

    imem_program_loader #(.ADDR_W(8), .INST_W(25), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: tracks position within the frame rather than loader states.
    bit         m_loading, m_wr, m_done, m_hold, m_err;
    int         m_pos, m_n, m_wc, m_addr;
    logic [7:0] m_xor;
    logic [7:0] m_bytes [4];
    logic [24:0] m_wdata;

    int         log_addr [$];
    int         log_data [$];
    int         done_cnt = 0;
    int         ready_in_wr = 0;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic model_reset();
        m_loading = 0; m_wr = 0; m_done = 0; m_hold = 1; m_err = 0;
        m_pos = 0; m_n = 0; m_wc = 0; m_addr = 0; m_xor = 8'h00; m_wdata = '0;
    endtask

    task automatic model_step();
        bit was_done;
        int k;
        was_done = m_done;
        m_done = 0;
        if (m_wr) begin
            m_addr = (m_addr + 1) % 256;
            m_wc++;
            m_wr = 0;
        end else if (m_loading && byte_valid) begin
            if (m_pos < 0) begin
                m_n = byte_data;
                m_xor = m_xor ^ byte_data;
                m_pos = 0;
            end else if (m_pos < 4 * m_n) begin
                k = m_pos % 4;
                if (k == 0 && byte_data > 8'd1) begin
                    m_loading = 0;
                    m_err = 1;
                end else begin
                    m_bytes[k] = byte_data;
                    m_xor = m_xor ^ byte_data;
                    m_pos++;
                    if (k == 3) begin
                        m_wdata = {m_bytes[0][0], m_bytes[1], m_bytes[2], m_bytes[3]};
                        m_wr = 1;
                    end
                end
            end else begin
                m_loading = 0;
                if (byte_data == m_xor) begin
                    m_done = 1;
                    m_hold = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (!m_loading && !was_done && start) begin
            m_loading = 1; m_pos = -1; m_xor = 8'h00; m_wc = 0;
            m_err = 0; m_hold = 1; m_addr = 0;
        end
    endtask

    // Single compare process: checks outputs at the falling edge, advances the model at the rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!Reset) model_reset();
            check_output("byte_ready", byte_ready, m_loading && !m_wr);
            check_output("imem_we", imem_we, m_wr);
            check_output("imem_addr", imem_addr, m_addr);
            check_output("word_count", word_count, m_wc);
            check_output("busy", busy, m_loading);
            check_output("done", done, m_done);
            check_output("err", err, m_err);
            check_output("cpu_hold", cpu_hold, m_hold);
            if (imem_we) begin
                check_output("imem_wdata", imem_wdata, m_wdata);
                log_addr.push_back(int'(imem_addr));
                log_data.push_back(int'(imem_wdata));
                if (byte_ready) ready_in_wr++;
            end
            if (done) done_cnt++;
            @(posedge clk);
            if (!Reset) model_reset();
            else model_step();
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        bit got;
        got = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (byte_ready) got = 1;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        if (!got) check_output("byte_accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [7:0] bytes [$], input int gap, input int start_at);
        foreach (bytes[i]) begin
            if (i == start_at) pulse_start();
            else if (i > 0) tick(gap);
            apply_stimulus(bytes[i]);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic expect_good_two_words(input string tag);
        check_output({tag, "_writes"}, log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check_output({tag, "_addr0"}, log_addr[0], 0);
            check_output({tag, "_data0"}, log_data[0], 32'h1234567);
            check_output({tag, "_addr1"}, log_addr[1], 1);
            check_output({tag, "_data1"}, log_data[1], 32'h0AABBCC);
        end
        check_output({tag, "_done_pulses"}, done_cnt, 1);
        check_output({tag, "_word_count"}, word_count, 2);
        check_output({tag, "_cpu_hold"}, cpu_hold, 0);
        check_output({tag, "_err"}, err, 0);
    endtask

    task automatic expect_reset_values(input string tag);
        @(negedge clk);
        check_output({tag, "_byte_ready"}, byte_ready, 0);
        check_output({tag, "_imem_we"}, imem_we, 0);
        check_output({tag, "_imem_addr"}, imem_addr, 0);
        check_output({tag, "_imem_wdata"}, imem_wdata, 0);
        check_output({tag, "_cpu_hold"}, cpu_hold, 1);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_err"}, err, 0);
        check_output({tag, "_word_count"}, word_count, 0);
        tick(1);
    endtask

    logic [7:0] frame_ok [$];
    logic [7:0] frame_bad [$];
    logic [7:0] frame_partial [$];

    initial begin
        frame_ok      = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDF};
        frame_bad     = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        frame_partial = '{8'h02, 8'h01, 8'h23, 8'h45};
        Reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        tick(2);
        expect_reset_values("reset");
        Reset = 1'b1;
        tick(2);

        $display("[TB] case 1: good two-word frame at full rate");
        clear_log();
        pulse_start();
        send_frame(frame_ok, 0, -1);
        tick(3);
        expect_good_two_words("case1");

        $display("[TB] case 2: bad checksum");
        clear_log();
        pulse_start();
        check_output("case2_hold_reasserted", cpu_hold, 1);
        send_frame(frame_bad, 0, -1);
        tick(3);
        check_output("case2_writes", log_addr.size(), 2);
        if (log_data.size() > 0) check_output("case2_data0", log_data[0], 32'h1234567);
        check_output("case2_err", err, 1);
        check_output("case2_done_pulses", done_cnt, 0);
        check_output("case2_cpu_hold", cpu_hold, 1);

        $display("[TB] case 3: reserved bit set in first payload byte");
        clear_log();
        pulse_start();
        check_output("case3_err_cleared", err, 0);
        send_frame('{8'h01, 8'h02}, 0, -1);
        tick(3);
        check_output("case3_writes", log_addr.size(), 0);
        check_output("case3_err", err, 1);
        check_output("case3_busy", busy, 0);
        check_output("case3_cpu_hold", cpu_hold, 1);

        $display("[TB] case 4: empty program");
        clear_log();
        pulse_start();
        send_frame('{8'h00, 8'h00}, 0, -1);
        tick(3);
        check_output("case4_writes", log_addr.size(), 0);
        check_output("case4_done_pulses", done_cnt, 1);
        check_output("case4_word_count", word_count, 0);
        check_output("case4_cpu_hold", cpu_hold, 0);
        check_output("case4_err", err, 0);

        $display("[TB] case 5: stalled stream with stray start");
        clear_log();
        pulse_start();
        send_frame(frame_ok, 1, 5);
        tick(3);
        expect_good_two_words("case5");
        check_output("ready_during_write", ready_in_wr, 0);

        $display("[TB] case 6: reset mid-word, then reload");
        clear_log();
        pulse_start();
        send_frame(frame_partial, 0, -1);
        Reset = 1'b0;
        expect_reset_values("case6");
        check_output("case6_writes", log_addr.size(), 0);
        Reset = 1'b1;
        tick(2);
        clear_log();
        pulse_start();
        send_frame(frame_ok, 0, -1);
        tick(3);
        expect_good_two_words("case6_rerun");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
